// File: rtl/dcp_run_ctrl_pkg.sv
// Shared encodings for the DCP run controller: command opcodes, stop codes and FSM states.
package dcp_run_ctrl_pkg;

   localparam logic [2:0] OP_STEP       = 3'd1;
   localparam logic [2:0] OP_GO         = 3'd2;
   localparam logic [2:0] OP_HALT       = 3'd3;
   localparam logic [2:0] OP_BP_SET     = 3'd4;
   localparam logic [2:0] OP_BP_CLR     = 3'd5;
   localparam logic [2:0] OP_BP_CLR_ALL = 3'd6;

   localparam logic [1:0] SC_OK     = 2'd0;
   localparam logic [1:0] SC_BP_HIT = 2'd1;
   localparam logic [1:0] SC_HALTED = 2'd2;
   localparam logic [1:0] SC_ERR    = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HI    = 3'd1,
      ST_LO    = 3'd2,
      ST_CHECK = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

endpackage

// File: rtl/dcp_bp_table.sv
// Breakpoint table: NUM_BP {valid, addr} entries with set/clear ports, combinational
// lookups against the command address and the CPU next PC, and a registered occupancy count.
module dcp_bp_table
   import dcp_run_ctrl_pkg::*;
#(
   parameter int NUM_BP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_i,
   input  logic        clr_i,
   input  logic        clr_all_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] npc_i,
   output logic        match_o,
   output logic        present_o,
   output logic        full_o,
   output logic [4:0]  cnt_o
);

   localparam int IW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

   logic [NUM_BP-1:0] valid_q, valid_d;
   logic [31:0]       addr_q [NUM_BP];
   logic [4:0]        cnt_q;
   logic [IW-1:0]     pidx, fidx;
   logic              free;
   logic              do_set;

   function automatic logic [4:0] popcount(input logic [NUM_BP-1:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < NUM_BP; i++) c = c + 5'(v[i]);
      return c;
   endfunction

   always_comb begin
      present_o = 1'b0;
      match_o   = 1'b0;
      pidx      = '0;
      free      = 1'b0;
      fidx      = '0;
      for (int i = 0; i < NUM_BP; i++) begin
         if (valid_q[i] && addr_q[i] == addr_i) begin
            present_o = 1'b1;
            pidx      = IW'(i);
         end
         if (valid_q[i] && addr_q[i] == npc_i) match_o = 1'b1;
      end
      // Scan downwards so the lowest free entry is the one left selected.
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free = 1'b1;
            fidx = IW'(i);
         end
      end
   end

   assign full_o = ~free;
   assign do_set = set_i & ~present_o & free;

   always_comb begin
      valid_d = valid_q;
      if (clr_all_i)                valid_d = '0;
      else if (do_set)              valid_d[fidx] = 1'b1;
      else if (clr_i && present_o)  valid_d[pidx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= popcount(valid_d);
      end
   end

   // Address storage is qualified by valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (do_set) addr_q[fidx] <= addr_i;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dcp_run_ctrl.sv
// CPU clock sequencer for the debug control unit: step, free-run, halt and breakpoint
// commands; sole driver of clk_cpu, reports stop reason and stop PC on done.
module dcp_run_ctrl
   import dcp_run_ctrl_pkg::*;
#(
   parameter int NUM_BP   = 4,
   parameter int PULSE_HI = 2,
   parameter int PULSE_LO = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_vld,
   output logic        cmd_rdy,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_arg,
   output logic        done,
   output logic [1:0]  stop_code,
   output logic [31:0] stop_pc,
   output logic        busy,
   output logic [4:0]  bp_cnt,
   output logic        clk_cpu,
   input  logic        pc_chk,
   input  logic [31:0] npc
);

   localparam int PMAX = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
   localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mode_go_q, mode_go_d;
   logic          halt_q, halt_d;
   logic          done_q, busy_q, clk_cpu_q;
   logic [1:0]    code_q, code_d;
   logic [31:0]   pc_q, pc_d;
   logic          bp_set, bp_clr, bp_clr_all;
   logic          bp_match, bp_present, bp_full;
   logic          halt_req;

   dcp_bp_table #(.NUM_BP(NUM_BP)) u_bp_table (
      .clk       (clk),
      .rst       (rst),
      .set_i     (bp_set),
      .clr_i     (bp_clr),
      .clr_all_i (bp_clr_all),
      .addr_i    (cmd_arg),
      .npc_i     (npc),
      .match_o   (bp_match),
      .present_o (bp_present),
      .full_o    (bp_full),
      .cnt_o     (bp_cnt)
   );

   assign halt_req = cmd_vld & (cmd_op == OP_HALT);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mode_go_d  = mode_go_q;
      halt_d     = halt_q;
      code_d     = SC_OK;
      pc_d       = '0;
      cmd_rdy    = 1'b0;
      bp_set     = 1'b0;
      bp_clr     = 1'b0;
      bp_clr_all = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cmd_rdy = 1'b1;
            halt_d  = 1'b0;
            if (cmd_vld) begin
               state_d = ST_RESP;
               unique case (cmd_op)
                  OP_STEP, OP_GO: begin
                     state_d   = ST_HI;
                     cnt_d     = '0;
                     mode_go_d = (cmd_op == OP_GO);
                  end
                  OP_HALT: begin
                     code_d = SC_HALTED;
                     pc_d   = npc;
                  end
                  OP_BP_SET: begin
                     bp_set = 1'b1;
                     code_d = (!bp_present && bp_full) ? SC_ERR : SC_OK;
                  end
                  OP_BP_CLR: begin
                     bp_clr = 1'b1;
                     code_d = bp_present ? SC_OK : SC_ERR;
                  end
                  OP_BP_CLR_ALL: bp_clr_all = 1'b1;
                  default:       code_d = SC_ERR;
               endcase
            end
         end
         // A HALT while running is only latched; the pulse in flight always completes.
         ST_HI: begin
            cmd_rdy = (cmd_op == OP_HALT);
            if (halt_req) halt_d = 1'b1;
            if (cnt_q == CW'(PULSE_HI - 1)) begin
               state_d = ST_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_LO: begin
            cmd_rdy = (cmd_op == OP_HALT);
            if (halt_req) halt_d = 1'b1;
            if (cnt_q == CW'(PULSE_LO - 1)) begin
               state_d = ST_CHECK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CHECK: begin
            cmd_rdy = (cmd_op == OP_HALT);
            pc_d    = npc;
            state_d = ST_RESP;
            if (halt_q || halt_req)     code_d = SC_HALTED;
            else if (pc_chk && bp_match) code_d = SC_BP_HIT;
            else if (!mode_go_q)         code_d = SC_OK;
            else begin
               state_d = ST_HI;
               pc_d    = '0;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            halt_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mode_go_q <= 1'b0;
         halt_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         clk_cpu_q <= 1'b0;
         code_q    <= SC_OK;
         pc_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mode_go_q <= mode_go_d;
         halt_q    <= halt_d;
         done_q    <= (state_d == ST_RESP);
         busy_q    <= (state_d == ST_HI) || (state_d == ST_LO) || (state_d == ST_CHECK);
         clk_cpu_q <= (state_d == ST_HI);
         code_q    <= (state_d == ST_RESP) ? code_d : SC_OK;
         pc_q      <= (state_d == ST_RESP) ? pc_d : '0;
      end
   end

   assign done      = done_q;
   assign busy      = busy_q;
   assign clk_cpu   = clk_cpu_q;
   assign stop_code = code_q;
   assign stop_pc   = pc_q;

endmodule

// File: tb/tb_dcp_run_ctrl.sv
// Directed bench for dcp_run_ctrl: step/go/halt sequencing, breakpoint table ops and reset.
module tb_dcp_run_ctrl;

   localparam logic [2:0] T_STEP = 3'd1, T_GO = 3'd2, T_HALT = 3'd3;
   localparam logic [2:0] T_SET = 3'd4, T_CLR = 3'd5, T_CLRALL = 3'd6;
   localparam logic [1:0] C_OK = 2'd0, C_BP = 2'd1, C_HALT = 2'd2, C_ERR = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_arg;
   logic        done;
   logic [1:0]  stop_code;
   logic [31:0] stop_pc;
   logic        busy;
   logic [4:0]  bp_cnt;
   logic        clk_cpu;
   logic        pc_chk;
   logic [31:0] npc;

   int n_cmp = 0;
   int n_err = 0;
   int pulses = 0;
   int hi_cycles = 0;
   int done_seen = 0;
   logic inc_en = 1'b0;

   dcp_run_ctrl #(.NUM_BP(4), .PULSE_HI(2), .PULSE_LO(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_vld   (cmd_vld),
      .cmd_rdy   (cmd_rdy),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .done      (done),
      .stop_code (stop_code),
      .stop_pc   (stop_pc),
      .busy      (busy),
      .bp_cnt    (bp_cnt),
      .clk_cpu   (clk_cpu),
      .pc_chk    (pc_chk),
      .npc       (npc)
   );

   always #5 clk = ~clk;

   // CPU model: next PC advances by 4 on each CPU clock rising edge.
   always @(posedge clk_cpu) begin
      pulses = pulses + 1;
      if (inc_en) npc = npc + 32'd4;
   end

   always @(posedge clk) begin
      if (clk_cpu) hi_cycles = hi_cycles + 1;
      if (done) done_seen = done_seen + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] arg);
      int k;
      cmd_op  = op;
      cmd_arg = arg;
      cmd_vld = 1'b1;
      k = 0;
      while (!cmd_rdy && k < 100) begin
         tick();
         k++;
      end
      if (!cmd_rdy) chk("rdy_timeout", 32'(cmd_rdy), 32'd1);
      tick();
      cmd_vld = 1'b0;
   endtask

   task automatic wait_done(output int lat, output logic [1:0] code,
                            output logic [31:0] pc, output logic [5:0] seq);
      lat = 1;
      seq = '0;
      while (!done && lat < 200) begin
         if (lat <= 6) seq[6-lat] = clk_cpu;
         tick();
         lat++;
      end
      if (!done) chk("done_timeout", 32'(done), 32'd1);
      code = stop_code;
      pc   = stop_pc;
   endtask

   task automatic bp_op(input string tag, input logic [2:0] op, input logic [31:0] arg,
                        input logic [1:0] exp_code, input int exp_cnt);
      int lat;
      logic [1:0] code;
      logic [31:0] pc;
      logic [5:0] seq;
      send(op, arg);
      wait_done(lat, code, pc, seq);
      chk({tag, "_code"}, 32'(code), 32'(exp_code));
      chk({tag, "_cnt"}, 32'(bp_cnt), 32'(exp_cnt));
   endtask

   initial begin
      int lat;
      logic [1:0] code;
      logic [31:0] pc;
      logic [5:0] seq;
      int p0, h0, d0;

      rst = 1'b1; cmd_vld = 1'b0; cmd_op = '0; cmd_arg = '0;
      pc_chk = 1'b0; npc = '0;
      repeat (3) tick();
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_clkcpu", 32'(clk_cpu), 32'd0);
      chk("rst_bpcnt", 32'(bp_cnt), 32'd0);
      chk("rst_stoppc", stop_pc, 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_rdy", 32'(cmd_rdy), 32'd1);

      // Single step
      npc = 32'h0000_3004;
      send(T_STEP, '0);
      chk("step_busy", 32'(busy), 32'd1);
      wait_done(lat, code, pc, seq);
      chk("step_lat", 32'(lat), 32'd6);
      chk("step_clkseq", 32'(seq), 32'b110000);
      chk("step_code", 32'(code), 32'(C_OK));
      chk("step_pc", pc, 32'h3004);
      chk("step_busy_end", 32'(busy), 32'd0);
      chk("step_rdy_resp", 32'(cmd_rdy), 32'd0);

      // Free run into a breakpoint
      bp_op("set3010", T_SET, 32'h3010, C_OK, 1);
      npc = 32'h3000; pc_chk = 1'b1; inc_en = 1'b1; p0 = pulses;
      send(T_GO, '0);
      wait_done(lat, code, pc, seq);
      chk("go_bp_code", 32'(code), 32'(C_BP));
      chk("go_bp_pc", pc, 32'h3010);
      chk("go_bp_pulses", 32'(pulses - p0), 32'd4);

      // Free run, then HALT after 10 cycles; pulse in flight completes
      bp_op("clrall0", T_CLRALL, '0, C_OK, 0);
      npc = 32'h4000; p0 = pulses; h0 = hi_cycles;
      send(T_GO, '0);
      cmd_op = T_SET;
      chk("run_rdy_stall", 32'(cmd_rdy), 32'd0);
      repeat (10) tick();
      send(T_HALT, '0);
      wait_done(lat, code, pc, seq);
      chk("halt_code", 32'(code), 32'(C_HALT));
      chk("halt_pc", pc, npc);
      chk("halt_clkcpu", 32'(clk_cpu), 32'd0);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_pulses", 32'(pulses - p0), 32'd3);
      chk("halt_fullpulse", 32'(hi_cycles - h0), 32'(2 * (pulses - p0)));
      inc_en = 1'b0;

      // HALT while idle
      npc = 32'h1234;
      send(T_HALT, '0);
      wait_done(lat, code, pc, seq);
      chk("idlehalt_lat", 32'(lat), 32'd1);
      chk("idlehalt_code", 32'(code), 32'(C_HALT));
      chk("idlehalt_pc", pc, 32'h1234);

      // Breakpoint table management
      bp_op("set10", T_SET, 32'h10, C_OK, 1);
      chk("bpop_pc", stop_pc, 32'd0);
      bp_op("set20", T_SET, 32'h20, C_OK, 2);
      bp_op("set30", T_SET, 32'h30, C_OK, 3);
      bp_op("set40", T_SET, 32'h40, C_OK, 4);
      bp_op("set50_full", T_SET, 32'h50, C_ERR, 4);
      bp_op("set20_dup", T_SET, 32'h20, C_OK, 4);
      bp_op("clr99", T_CLR, 32'h99, C_ERR, 4);
      bp_op("clr20", T_CLR, 32'h20, C_OK, 3);
      bp_op("set60_reuse", T_SET, 32'h60, C_OK, 4);
      bp_op("clrall", T_CLRALL, '0, C_OK, 0);
      bp_op("illegal7", 3'd7, '0, C_ERR, 0);
      bp_op("illegal0", 3'd0, '0, C_ERR, 0);

      // HALT accepted in the same cycle CHECK sees a breakpoint match
      bp_op("set3004", T_SET, 32'h3004, C_OK, 1);
      npc = 32'h3000; inc_en = 1'b1;
      send(T_GO, '0);
      repeat (4) tick();
      send(T_HALT, '0);
      wait_done(lat, code, pc, seq);
      chk("race_code", 32'(code), 32'(C_HALT));
      chk("race_pc", pc, 32'h3004);
      inc_en = 1'b0;

      // Reset while clk_cpu is high
      npc = 32'h8000;
      send(T_GO, '0);
      chk("pre_rst_clkcpu", 32'(clk_cpu), 32'd1);
      d0 = done_seen;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_clkcpu", 32'(clk_cpu), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_bpcnt", 32'(bp_cnt), 32'd0);
      repeat (8) tick();
      chk("midrst_nodone", 32'(done_seen - d0), 32'd0);
      npc = 32'h5000;
      send(T_STEP, '0);
      wait_done(lat, code, pc, seq);
      chk("post_rst_lat", 32'(lat), 32'd6);
      chk("post_rst_code", 32'(code), 32'(C_OK));
      chk("post_rst_pc", pc, 32'h5000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
